// File: rtl/full_adder.sv
// One-bit full adder with a combinational path and a registered path that can
// chain its own carry for bit-serial addition (LSB first).
module full_adder (
   input  logic clk,
   input  logic rst,
   input  logic A,
   input  logic B,
   input  logic Cin,
   input  logic en,
   input  logic serial,
   output logic Sum,
   output logic Cout,
   output logic Sum_q,
   output logic Cout_q,
   output logic valid_q
);

   logic c_eff;
   logic sum_d;
   logic cout_d;

   // Combinational adder: depends on A, B, Cin only.
   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (A & Cin) | (B & Cin);

   // Serial mode recirculates the stored carry instead of Cin.
   always_comb begin
      c_eff  = Cin;
      if (serial) begin
         c_eff = Cout_q;
      end
      sum_d  = A ^ B ^ c_eff;
      cout_d = (A & B) | (A & c_eff) | (B & c_eff);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Sum_q   <= 1'b0;
         Cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (en) begin
         Sum_q   <= sum_d;
         Cout_q  <= cout_d;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: combinational truth table,
// registered parallel/hold behaviour, bit-serial chains and reset priority.
module tb_full_adder;

   logic clk;
   logic clk_on;
   logic rst;
   logic A;
   logic B;
   logic Cin;
   logic en;
   logic serial;
   logic Sum;
   logic Cout;
   logic Sum_q;
   logic Cout_q;
   logic valid_q;

   int n_cmp;
   int n_err;

   full_adder dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .Cin     (Cin),
      .en      (en),
      .serial  (serial),
      .Sum     (Sum),
      .Cout    (Cout),
      .Sum_q   (Sum_q),
      .Cout_q  (Cout_q),
      .valid_q (valid_q)
   );

   // Clock stays idle until the combinational test has finished.
   always begin
      #5;
      if (clk_on) clk = ~clk;
   end

   // Advance one rising edge and settle 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_q(input string name, input logic [2:0] exp);
      logic [2:0] got;
      got = {Sum_q, Cout_q, valid_q};
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: {Sum_q,Cout_q,valid_q} got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_c(input string name, input logic [1:0] exp);
      logic [1:0] got;
      got = {Sum, Cout};
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: {Sum,Cout} got %b expected %b", name, got, exp);
      end
   endtask

   task automatic test_comb();
      logic [1:0] exp_tab [8];
      logic [2:0] v;
      exp_tab = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {A, B, Cin} = v;
         #10;
         chk_c($sformatf("comb_%b", v), exp_tab[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; serial = 1'b0;
      A = 1'b1; B = 1'b1; Cin = 1'b1;
      tick();
      chk_q("reset_state", 3'b000);
      rst = 1'b0;
   endtask

   task automatic test_parallel();
      en = 1'b1; serial = 1'b0;
      A = 1'b1; B = 1'b1; Cin = 1'b1;
      tick();
      chk_q("parallel_111", 3'b111);
   endtask

   task automatic test_hold();
      en = 1'b0;
      A = 1'b0; B = 1'b0; Cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_q($sformatf("hold_q_%0d", i), 3'b111);
         chk_c($sformatf("hold_c_%0d", i), 2'b00);
      end
   endtask

   // 0111 + 0101 LSB first, with an idle cycle that must keep the carry.
   task automatic test_serial_add();
      logic [3:0] a_v;
      logic [3:0] b_v;
      logic [3:0] s_exp;
      logic [3:0] c_exp;
      a_v = 4'b0111; b_v = 4'b0101;
      s_exp = 4'b1100; c_exp = 4'b0111;
      rst = 1'b1; tick(); rst = 1'b0;
      serial = 1'b1; Cin = 1'b1;
      for (int k = 0; k < 4; k++) begin
         en = 1'b1; A = a_v[k]; B = b_v[k];
         tick();
         chk_q($sformatf("serial_add_bit%0d", k), {s_exp[k], c_exp[k], 1'b1});
         if (k == 1) begin
            en = 1'b0; A = 1'b0; B = 1'b0;
            tick();
            chk_q("serial_add_idle", {s_exp[k], c_exp[k], 1'b1});
         end
      end
   endtask

   // 1111 + 0001 overflows; reset then clears the stored carry.
   task automatic test_serial_overflow();
      logic [3:0] a_v;
      logic [3:0] b_v;
      a_v = 4'b1111; b_v = 4'b0001;
      rst = 1'b1; tick(); rst = 1'b0;
      serial = 1'b1; en = 1'b1; Cin = 1'b0;
      for (int k = 0; k < 4; k++) begin
         A = a_v[k]; B = b_v[k];
         tick();
         chk_q($sformatf("overflow_bit%0d", k), 3'b011);
      end
      rst = 1'b1;
      tick();
      chk_q("overflow_reset", 3'b000);
      rst = 1'b0;
      A = 1'b1; B = 1'b0; Cin = 1'b1;
      tick();
      chk_q("serial_after_reset", 3'b101);
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; en = 1'b1; serial = 1'b0;
      A = 1'b1; B = 1'b1; Cin = 1'b1;
      tick();
      chk_q("rst_priority_q", 3'b000);
      chk_c("rst_priority_c", 2'b11);
      rst = 1'b0;
   endtask

   // Stored carry is 1; parallel mode must use Cin=0, then serial picks it up.
   task automatic test_mode_switch();
      en = 1'b1; serial = 1'b0;
      A = 1'b1; B = 1'b1; Cin = 1'b0;
      tick();
      chk_q("switch_setup", 3'b011);
      A = 1'b1; B = 1'b0; Cin = 1'b0;
      tick();
      chk_q("switch_parallel", 3'b101);
      A = 1'b1; B = 1'b1; Cin = 1'b1;
      tick();
      serial = 1'b1; A = 1'b0; B = 1'b0; Cin = 1'b0;
      tick();
      chk_q("switch_serial", 3'b101);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clk_on = 1'b0;
      test_comb();
      clk = 1'b0;
      clk_on = 1'b1;
      test_reset();
      test_parallel();
      test_hold();
      test_serial_add();
      test_serial_overflow();
      test_reset_priority();
      test_mode_switch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk is the single clock and rst is the reset, sampled only on the rising edge of clk.
REQ-003 clk  input  1  rising-edge clock for all registered state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 A  input  1  addend bit.
REQ-006 B  input  1  addend bit.
REQ-007 Cin  input  1  carry-in bit.
REQ-008 en  input  1  register-update enable.
REQ-009 serial  input  1  when 1, the registered path uses the stored carry instead of Cin (bit-serial addition).
REQ-010 Sum  output  1  combinational sum: A xor B xor Cin.
REQ-011 Cout  output  1  combinational carry: majority(A, B, Cin).
REQ-012 Sum_q  output  1  registered sum.
REQ-013 Cout_q  output  1  registered carry; also the stored carry for serial mode.
REQ-014 valid_q  output  1  high when Sum_q/Cout_q hold a result computed since the last reset.

Function
REQ-015 Sum and Cout SHALL be purely combinational functions of A, B and Cin only; they are independent of clk, rst, en, serial and all state, and remain correct with clk/rst/en/serial undriven.
REQ-016 Sum/Cout truth table (A B Cin -> Sum Cout):
- 000->00, 001->10, 010->10, 011->01
- 100->10, 101->01, 110->01, 111->11
REQ-017 Sum and Cout SHALL settle within the same simulation time step as an input change (zero clock latency).
REQ-018 Registered-path carry-in c_eff SHALL be Cout_q when serial=1, else Cin.
REQ-019 On a clk rising edge with rst=0 and en=1: Sum_q <= A^B^c_eff; Cout_q <= majority(A, B, c_eff); valid_q <= 1.
REQ-020 On a clk rising edge with rst=0 and en=0, Sum_q, Cout_q and valid_q SHALL hold their values.
REQ-021 Registered outputs SHALL have one-cycle latency: the result of inputs sampled at edge N is visible after edge N.
REQ-022 In serial mode, the carry out of bit k SHALL be used as carry-in of bit k+1 on the next enabled edge; disabled cycles (en=0) do not consume or alter the stored carry.
REQ-023 Changing serial between cycles SHALL take effect at the next enabled edge with no extra state.

Reset
REQ-024 On a clk rising edge with rst=1: Sum_q=0, Cout_q=0, valid_q=0, regardless of en, serial, A, B, Cin.
REQ-025 rst SHALL have priority over en; a reset mid serial sequence clears the stored carry, so the next serial bit starts with carry-in 0.
REQ-026 rst SHALL NOT affect Sum or Cout.
REQ-027 Before the first reset, registered outputs are undefined; benches SHALL apply rst for at least one edge first.

Verification
REQ-028 Exhaustive combinational: step A,B,Cin through 000..111, 10 ns each, no clock -> Sum/Cout match REQ-016 for all 8 vectors.
REQ-029 Registered parallel: rst, then en=1, serial=0, A=1, B=1, Cin=1 for one edge -> Sum_q=1, Cout_q=1, valid_q=1 after that edge.
REQ-030 Hold: after REQ-029, en=0, A=B=Cin=0 for 3 edges -> Sum_q=1, Cout_q=1 unchanged; Sum=0, Cout=0.
REQ-031 Serial 4-bit add, LSB first: 0b0111+0b0101, serial=1, en=1, Cin ignored -> Sum_q bits 0,0,1,1; final Cout_q=0 (result 12).
REQ-032 Serial overflow: 0b1111+0b0001 -> Sum_q bits 0,0,0,0; final Cout_q=1; then rst for one edge -> Sum_q=0, Cout_q=0, valid_q=0.
REQ-033 Reset priority: rst=1 and en=1 with A=B=Cin=1 on the same edge -> Sum_q=0, Cout_q=0, valid_q=0, while Sum=1, Cout=1.
